// File: rtl/pdm_clk_gen_pkg.sv
// Shared audio-path constants and the PDM clock generator state encoding.
package pdm_clk_gen_pkg;

  localparam int unsigned SYS_CLK_HZ       = 100_000_000;
  localparam int unsigned MIC_CLK_HZ       = 2_000_000;

  localparam int unsigned HALF_W_DEF       = 16;
  localparam int unsigned DEC_W_DEF        = 8;
  localparam int unsigned HALF_DEFAULT_DEF = SYS_CLK_HZ / (2 * MIC_CLK_HZ);
  localparam int unsigned DEC_DEFAULT_DEF  = 64;

  typedef logic [1:0] pdm_state_t;

  localparam pdm_state_t ST_IDLE     = 2'd0;
  localparam pdm_state_t ST_RUN_LO   = 2'd1;
  localparam pdm_state_t ST_RUN_HI   = 2'd2;
  localparam pdm_state_t ST_STOPPING = 2'd3;

endpackage

// File: rtl/pdm_clk_gen_if.sv
// Configuration valid/ready channel carrying half-period and decimation ratio.
interface pdm_clk_gen_if
  import pdm_clk_gen_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEF,
  parameter int unsigned DEC_W  = DEC_W_DEF
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [HALF_W-1:0] cfg_half;
  logic [DEC_W-1:0]  cfg_dec;

  modport master (output cfg_valid, output cfg_half, output cfg_dec, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_half, input cfg_dec, output cfg_ready);

endinterface

// File: rtl/cfg_shadow.sv
// Single-entry valid/ready shadow register; the owner pulses apply to consume it.
module cfg_shadow #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         apply,
  output logic         pending,
  output logic [W-1:0] data
);

  logic take_c;

  assign take_c = in_valid && in_ready;

  // A take in the same cycle as an apply leaves the new entry pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      in_ready <= 1'b1;
      data     <= '0;
    end else if (take_c) begin
      pending  <= 1'b1;
      in_ready <= 1'b0;
      data     <= in_data;
    end else if (apply) begin
      pending  <= 1'b0;
      in_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/pdm_clk_gen.sv
// Runtime-programmable PDM microphone clock with edge and decimated sample strobes.
module pdm_clk_gen
  import pdm_clk_gen_pkg::*;
#(
  parameter int unsigned HALF_W       = HALF_W_DEF,
  parameter int unsigned DEC_W        = DEC_W_DEF,
  parameter int unsigned HALF_DEFAULT = HALF_DEFAULT_DEF,
  parameter int unsigned DEC_DEFAULT  = DEC_DEFAULT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  pdm_clk_gen_if.slave        cfg,
  output logic                mic_clk,
  output logic                rise_stb,
  output logic                fall_stb,
  output logic                sample_stb,
  output logic                active,
  output logic                led
);

  localparam logic [HALF_W-1:0] HALF_RST = (HALF_DEFAULT == 0) ? HALF_W'(1) : HALF_W'(HALF_DEFAULT);
  localparam logic [DEC_W-1:0]  DEC_RST  = (DEC_DEFAULT == 0)  ? DEC_W'(1)  : DEC_W'(DEC_DEFAULT);

  pdm_state_t              state, state_n;
  logic [HALF_W-1:0]       cnt, cnt_n;
  logic [HALF_W-1:0]       live_half, live_half_n;
  logic [DEC_W-1:0]        live_dec, live_dec_n;
  logic [DEC_W-1:0]        edge_cnt, edge_cnt_n;
  logic                    mic_clk_n, rise_n, fall_n, sample_n;

  logic                    apply_c;
  logic                    term_c;
  logic                    sh_pending;
  logic [HALF_W+DEC_W-1:0] sh_data;
  logic [HALF_W-1:0]       sh_half_c, new_half_c;
  logic [DEC_W-1:0]        sh_dec_c, new_dec_c;

  cfg_shadow #(
    .W (HALF_W + DEC_W)
  ) u_cfg_shadow (
    .clk      (clk),
    .reset    (reset),
    .in_valid (cfg.cfg_valid),
    .in_ready (cfg.cfg_ready),
    .in_data  ({cfg.cfg_half, cfg.cfg_dec}),
    .apply    (apply_c),
    .pending  (sh_pending),
    .data     (sh_data)
  );

  // Zero in either field behaves as one.
  assign sh_half_c  = sh_data[HALF_W+DEC_W-1:DEC_W];
  assign sh_dec_c   = sh_data[DEC_W-1:0];
  assign new_half_c = (sh_half_c == '0) ? HALF_W'(1) : sh_half_c;
  assign new_dec_c  = (sh_dec_c == '0)  ? DEC_W'(1)  : sh_dec_c;
  assign term_c     = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= HALF_RST - HALF_W'(1);
      live_half  <= HALF_RST;
      live_dec   <= DEC_RST;
      edge_cnt   <= '0;
      mic_clk    <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      sample_stb <= 1'b0;
      active     <= 1'b0;
      led        <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      live_half  <= live_half_n;
      live_dec   <= live_dec_n;
      edge_cnt   <= edge_cnt_n;
      mic_clk    <= mic_clk_n;
      rise_stb   <= rise_n;
      fall_stb   <= fall_n;
      sample_stb <= sample_n;
      active     <= (state_n != ST_IDLE);
      led        <= 1'b0;
    end
  end

  // Next state, counters and strobes; pending config lands on IDLE or a falling toggle.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    live_half_n = live_half;
    live_dec_n  = live_dec;
    edge_cnt_n  = edge_cnt;
    mic_clk_n   = mic_clk;
    rise_n      = 1'b0;
    fall_n      = 1'b0;
    sample_n    = 1'b0;
    apply_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        apply_c   = sh_pending;
        mic_clk_n = 1'b0;
        cnt_n     = (sh_pending ? new_half_c : live_half) - HALF_W'(1);
        if (enable) begin
          state_n = ST_RUN_LO;
        end
      end

      ST_RUN_LO: begin
        if (!enable) begin
          state_n = ST_IDLE;
          cnt_n   = live_half - HALF_W'(1);
        end else if (term_c) begin
          state_n   = ST_RUN_HI;
          mic_clk_n = 1'b1;
          rise_n    = 1'b1;
          cnt_n     = live_half - HALF_W'(1);
          if (edge_cnt == live_dec - DEC_W'(1)) begin
            sample_n   = 1'b1;
            edge_cnt_n = '0;
          end else begin
            edge_cnt_n = edge_cnt + DEC_W'(1);
          end
        end else begin
          cnt_n = cnt - HALF_W'(1);
        end
      end

      ST_RUN_HI, ST_STOPPING: begin
        // The high phase always runs to its terminal count before falling.
        if (term_c) begin
          apply_c   = sh_pending;
          mic_clk_n = 1'b0;
          fall_n    = 1'b1;
          cnt_n     = (sh_pending ? new_half_c : live_half) - HALF_W'(1);
          state_n   = enable ? ST_RUN_LO : ST_IDLE;
        end else begin
          cnt_n   = cnt - HALF_W'(1);
          state_n = enable ? ST_RUN_HI : ST_STOPPING;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (apply_c) begin
      live_half_n = new_half_c;
      live_dec_n  = new_dec_c;
      edge_cnt_n  = '0;
    end
  end

endmodule

// File: tb/tb_pdm_clk_gen.sv
// Scoreboard bench for pdm_clk_gen: expected strobe cycles are queued at stimulus time.
module tb_pdm_clk_gen;
  import pdm_clk_gen_pkg::*;

  localparam int unsigned HW = 16;
  localparam int unsigned DW = 8;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic mic_clk, rise_stb, fall_stb, sample_stb, active, led;

  pdm_clk_gen_if #(.HALF_W(HW), .DEC_W(DW)) cfg_if ();

  pdm_clk_gen #(
    .HALF_W       (HW),
    .DEC_W        (DW),
    .HALF_DEFAULT (25),
    .DEC_DEFAULT  (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg        (cfg_if),
    .mic_clk    (mic_clk),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .sample_stb (sample_stb),
    .active     (active),
    .led        (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rise;
    int   cyc;
    logic smp;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Pop and compare whenever the DUT raises a strobe; flag events that never came.
  task automatic mon();
    ev_t e;
    while (q.size() != 0 && q[0].cyc < cyc) begin
      chk("missed_stb_cycle", cyc, q[0].cyc);
      e = q.pop_front();
    end
    if (rise_stb || fall_stb || sample_stb) begin
      if (q.size() == 0) begin
        chk("unexpected_stb", {rise_stb, fall_stb, sample_stb}, 0);
      end else begin
        e = q.pop_front();
        chk("rise_stb", rise_stb, e.rise);
        chk("fall_stb", fall_stb, !e.rise);
        chk("stb_cycle", cyc, e.cyc);
        chk("sample_stb", sample_stb, e.smp);
        chk("mic_clk_at_stb", mic_clk, e.rise);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // n full periods of half h starting at a cycle where the counter holds h-1, edge counter 0.
  task automatic push_train(input int start, input int h, input int d, input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.rise = 1'b1; e.cyc = start + h + 2 * h * i; e.smp = ((i % d) == d - 1);
      q.push_back(e);
      e.rise = 1'b0; e.cyc = start + 2 * h * (i + 1); e.smp = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic cfg_write(input int h, input int d, output int acc);
    logic hs;
    int   b;
    hs  = 1'b0;
    b   = 0;
    acc = 0;
    cfg_if.cfg_half  = HW'(h);
    cfg_if.cfg_dec   = DW'(d);
    cfg_if.cfg_valid = 1'b1;
    while (!hs && b < 1000) begin
      hs  = cfg_if.cfg_ready;
      acc = cyc;
      step();
      b++;
    end
    cfg_if.cfg_valid = 1'b0;
    if (!hs) chk("cfg_accept_timeout", 0, 1);
  endtask

  task automatic start_run(input int h, input int d, input int n, output int t0);
    enable = 1'b1;
    t0     = cyc + 1;
    push_train(t0, h, d, n);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (q.size() != 0 && b < 20000) begin
      step();
      b++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic stop_low();
    enable = 1'b0;
    step();
    chk("active_after_stop", active, 0);
    chk("mic_clk_after_stop", mic_clk, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_mic_clk", mic_clk, 0);
    chk("rst_rise_stb", rise_stb, 0);
    chk("rst_fall_stb", fall_stb, 0);
    chk("rst_sample_stb", sample_stb, 0);
    chk("rst_active", active, 0);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
    chk("rst_led", led, 1);
  endtask

  initial begin
    int t0, acc;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half  = '0;
    cfg_if.cfg_dec   = '0;

    // Reset state and led release
    repeat (3) step();
    check_reset_vals();
    reset = 1'b0;
    step();
    chk("led_release", led, 0);
    repeat (5) step();

    // Reset defaults: half 25, dec 64, two sample periods
    start_run(25, 64, 128, t0);
    step();
    chk("active_running", active, 1);
    drain();
    stop_low();

    // Small divisors, cfg_ready timing in IDLE
    cfg_write(1, 1, acc);
    chk("rdy_fall_idle", cfg_if.cfg_ready, 0);
    step();
    chk("rdy_ret_idle", cfg_if.cfg_ready, 1);
    chk("rdy_ret_idle_cyc", cyc, acc + 2);
    start_run(1, 1, 4, t0);
    drain();
    stop_low();

    // Zero values clamp to 1
    cfg_write(0, 0, acc);
    step();
    start_run(1, 1, 3, t0);
    drain();
    stop_low();

    // Mid-run reconfiguration during a low phase
    cfg_write(4, 3, acc);
    step();
    start_run(4, 3, 2, t0);
    wait_until(t0 + 9);
    cfg_write(2, 3, acc);
    chk("reconf_accept_cyc", acc, t0 + 9);
    push_train(t0 + 16, 2, 3, 3);
    chk("rdy_fall_run", cfg_if.cfg_ready, 0);
    wait_until(t0 + 15);
    chk("rdy_hold_run", cfg_if.cfg_ready, 0);
    step();
    chk("rdy_ret_run", cfg_if.cfg_ready, 1);
    drain();
    stop_low();

    // Back-to-back config held while shadow busy
    cfg_write(3, 2, acc);
    step();
    start_run(3, 2, 2, t0);
    wait_until(t0 + 6);
    cfg_write(2, 2, acc);
    chk("rdy_fall_b2b", cfg_if.cfg_ready, 0);
    push_train(t0 + 12, 2, 2, 1);
    push_train(t0 + 16, 1, 2, 2);
    cfg_write(1, 2, acc);
    chk("b2b_accept_cyc", acc, t0 + 12);
    chk("rdy_fall_b2b2", cfg_if.cfg_ready, 0);
    wait_until(t0 + 15);
    chk("rdy_hold_b2b", cfg_if.cfg_ready, 0);
    step();
    chk("rdy_ret_b2b", cfg_if.cfg_ready, 1);
    drain();
    stop_low();

    // Disable one cycle after a rise: high phase completes
    cfg_write(5, 2, acc);
    step();
    start_run(5, 2, 1, t0);
    wait_until(t0 + 5);
    enable = 1'b0;
    step();
    chk("active_stopping", active, 1);
    chk("mic_clk_stopping", mic_clk, 1);
    wait_until(t0 + 9);
    chk("mic_clk_high_5th", mic_clk, 1);
    step();
    chk("mic_clk_after_fall", mic_clk, 0);
    step();
    chk("active_after_fall", active, 0);
    chk("stop_queue_empty", q.size(), 0);
    repeat (12) step();

    // Disable while low: immediate stop, no strobe
    enable = 1'b1;
    step();
    step();
    chk("active_low_run", active, 1);
    enable = 1'b0;
    step();
    chk("active_low_stop", active, 0);
    repeat (10) step();
    chk("mic_clk_low_stop", mic_clk, 0);

    // Reset in the middle of a high phase restores defaults
    cfg_write(6, 2, acc);
    step();
    start_run(6, 2, 1, t0);
    wait_until(t0 + 8);
    chk("mic_clk_pre_reset", mic_clk, 1);
    q.delete();
    reset  = 1'b1;
    enable = 1'b0;
    step();
    check_reset_vals();
    reset = 1'b0;
    step();
    chk("led_release2", led, 0);
    start_run(25, 64, 1, t0);
    drain();
    stop_low();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/pdm_clk_gen.md
# pdm_clk_gen

Programmable PDM microphone clock generator for the PCM audio capture path. It replaces the fixed-ratio toggle divider with a runtime-reconfigurable half-period and a decimation counter. Single-cycle edge and sample strobes let the PDM sampler and the decimation filter run in the `clk` domain without using `mic_clk` as a clock. It sits between the system clock and the microphone pad / CIC front end.

## Interface
- `HALF_W`, 16: width of the half-period value.
- `DEC_W`, 8: width of the decimation ratio.
- `HALF_DEFAULT`, 25: half-period in `clk` cycles after reset (100 MHz → 2 MHz `mic_clk`).
- `DEC_DEFAULT`, 64: `mic_clk` rising edges per `sample_stb` after reset.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: run request.
- `cfg_valid`, in, 1: new configuration offered.
- `cfg_half`, in, `HALF_W`: requested half-period.
- `cfg_dec`, in, `DEC_W`: requested decimation ratio.
- `cfg_ready`, out, 1: shadow register free; a transfer occurs when `cfg_valid && cfg_ready`.
- `mic_clk`, out, 1: registered PDM clock to the pad.
- `rise_stb`, out, 1: one-cycle pulse in the first cycle `mic_clk` reads 1.
- `fall_stb`, out, 1: one-cycle pulse in the first cycle `mic_clk` reads 0 after being high.
- `sample_stb`, out, 1: decimated sample tick, coincident with `rise_stb`.
- `active`, out, 1: generator running (`mic_clk` toggling or finishing a high phase).
- `led`, out, 1: registered copy of `reset`, for the board indicator.

## Operation
- **Reset values:**
  - `mic_clk`, `rise_stb`, `fall_stb`, `sample_stb`, `active` = 0.
  - `cfg_ready` = 1; `led` = 1, then 0 one cycle after `reset` drops.
  - Live half = `HALF_DEFAULT`; live dec = `DEC_DEFAULT`.
  - Half counter = half−1; edge counter = 0; shadow empty.
- **Zero clamping:** a value of 0 for half or dec is treated as 1, both at reset-default and at apply time.
- **States:**
  - IDLE: `mic_clk`=0, counter held at half−1.
  - RUN_LO / RUN_HI: counter decrements once per cycle. At 0 it toggles `mic_clk` and reloads half−1.
  - STOPPING: high phase completes normally, then go to IDLE.
- **Transitions:**
  - IDLE→RUN_LO when `enable`=1.
  - RUN_LO with `enable`=0 → IDLE immediately, with no strobe.
  - RUN_HI with `enable`=0 → STOPPING.
  - STOPPING→IDLE on the high-phase terminal count, with `fall_stb`.
  - `enable` reasserted during STOPPING → RUN_HI; the current high phase continues.
- `active` = 1 in RUN_LO, RUN_HI and STOPPING.
- **Edge counter:** increments on each rising toggle and wraps at dec−1. `sample_stb` fires on the rising toggle where the counter equals dec−1. With dec=1, `sample_stb` = `rise_stb`.
- **Configuration handshake:**
  - On handshake, the values latch into the shadow register and `cfg_ready` drops.
  - Apply point in IDLE: the next cycle.
  - Apply point when running: the cycle of the falling toggle (RUN_HI→RUN_LO). The new half is used for that reload, so no partial periods occur.
  - On apply: live values are updated, the edge counter clears to 0, the shadow empties and `cfg_ready` returns to 1.
  - A handshake in the same cycle as an apply is accepted for the next apply point; no configuration is lost.
- **Priority:** `reset` overrides everything. An apply in the same cycle as `enable` falling still updates the live values.

## Timing
- First rising edge lands `half` cycles after the first cycle `enable` is sampled 1. `mic_clk` period = 2·half `clk` cycles, 50 % duty.
- All outputs are registered; strobes coincide exactly with the `mic_clk` transition cycle.
- `sample_stb` period = 2·half·dec cycles.
- `cfg_ready` latency:
  - Running: it falls the cycle after the handshake and returns the cycle after the next falling toggle.
  - IDLE: it returns 2 cycles after the handshake.

## Structure
- Shared audio package holds:
  - the `HALF_W`/`DEC_W` defaults;
  - the state enum (IDLE, RUN_LO, RUN_HI, STOPPING);
  - the 100 MHz system-clock constant.
- One sub-module, `cfg_shadow`: a valid/ready single-entry register with an apply strobe. It is reused by other configurable audio blocks.

## Test plan
- **Reset defaults:** reset, `enable`=1, half=25, dec=64 → first `rise_stb` 25 cycles after enable; `mic_clk` period 50; `sample_stb` every 3200 cycles.
- **Small divisors:** config half=1, dec=1 in IDLE → `mic_clk` toggles every cycle; `rise_stb` = `sample_stb` every 2 cycles.
- **Mid-run reconfiguration:** running half=4, dec=3, config half=2 written during a low phase → the current period completes at 8 cycles; the new 4-cycle period starts at the falling toggle; the edge counter restarts (next `sample_stb` on the 3rd rise after the change).
- **Disable while high:** `enable` dropped 1 cycle after a rise with half=5 → `mic_clk` stays high for 5 cycles total; `fall_stb` fires; `active`=0 the next cycle. Disable while low → immediate stop, no strobe.
- **Back-to-back config:** a second `cfg_valid` held while `cfg_ready`=0 → not accepted until after the apply; both configs are applied in order at successive falling edges.
- **Zero values and reset:** `cfg_half`=0 → behaves as half=1. Reset asserted mid high phase → all outputs at reset values next cycle; `led`=1.
